// File: rtl/shift_counter_gen_pkg.sv
// Shared definitions for the ring/Johnson shift counter: mode encodings,
// reset-pattern and period helpers.
package shift_counter_gen_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Widest counter the reset-pattern helper can describe; callers truncate.
  localparam int unsigned PAT_MAX_W = 64;

  // Reset pattern: ring starts one-hot at the MSB, Johnson starts all zeros.
  function automatic logic [PAT_MAX_W-1:0] reset_pat(input int unsigned w, input logic mode);
    logic [PAT_MAX_W-1:0] p;
    p = '0;
    if (mode == MODE_RING) begin
      p = PAT_MAX_W'(1) << (w - 1);
    end
    return p;
  endfunction

  // Sequence length: WIDTH steps for ring, 2*WIDTH for Johnson.
  function automatic int unsigned period(input int unsigned w, input logic mode);
    return (mode == MODE_JOHNSON) ? (2 * w) : w;
  endfunction

endpackage

// File: rtl/shift_counter_legal_chk.sv
// Combinational legality check of a counter state for the current mode.
// Ring is legal with exactly one bit set; Johnson is legal with at most one
// transition between adjacent bits.
module shift_counter_legal_chk
  import shift_counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             mode_i,
  output logic             legal_c
);

  logic [WIDTH-2:0] trans_c;

  // Adjacent-bit transitions, then pick the rule for the active mode.
  always_comb begin
    trans_c = q_i[WIDTH-1:1] ^ q_i[WIDTH-2:0];
    legal_c = (mode_i == MODE_JOHNSON) ? $onehot0(trans_c) : $onehot(q_i);
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Parametrised ring/Johnson shift counter with direction, enable, parallel
// load, phase index and wrap pulse.
// Optional illegal-state self-correction: define SHIFT_COUNTER_GEN_SELFCORRECT_EN.
module shift_counter_gen
  import shift_counter_gen_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  localparam logic [IDX_W-1:0] RING_LAST = IDX_W'(period(WIDTH, MODE_RING) - 1);
  localparam logic [IDX_W-1:0] JOHN_LAST = IDX_W'(period(WIDTH, MODE_JOHNSON) - 1);
  localparam logic [WIDTH-1:0] RING_RST  = WIDTH'(reset_pat(WIDTH, MODE_RING));
  localparam logic [WIDTH-1:0] JOHN_RST  = WIDTH'(reset_pat(WIDTH, MODE_JOHNSON));

  logic [WIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             mode_q, mode_d;
  logic             err_d;
  logic             legal_c;
  logic [IDX_W-1:0] last_c;

`ifdef SHIFT_COUNTER_GEN_SELFCORRECT_EN
  logic err_q;

  shift_counter_legal_chk #(
    .WIDTH (WIDTH)
  ) u_legal_chk (
    .q_i     (q_q),
    .mode_i  (mode_q),
    .legal_c (legal_c)
  );
`else
  assign legal_c = 1'b1;
`endif

  // Next state: load > mode change > self-correct > step > hold.
  always_comb begin
    q_d    = q_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    mode_d = mode_q;
    last_c = (mode_q == MODE_JOHNSON) ? JOHN_LAST : RING_LAST;
    if (load) begin
      q_d    = load_val;
      idx_d  = '0;
      mode_d = mode;
    end else if (mode != mode_q) begin
      q_d    = (mode == MODE_JOHNSON) ? JOHN_RST : RING_RST;
      idx_d  = '0;
      mode_d = mode;
    end else if (!legal_c) begin
      q_d   = (mode_q == MODE_JOHNSON) ? JOHN_RST : RING_RST;
      idx_d = '0;
      err_d = 1'b1;
    end else if (en) begin
      if (!dir) begin
        // Johnson feeds back the inverted MSB; ring feeds it back unchanged.
        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ mode_q};
        idx_d  = (idx_q == last_c) ? '0 : idx_q + IDX_W'(1);
        wrap_d = (idx_q == last_c);
      end else begin
        q_d    = {q_q[0] ^ mode_q, q_q[WIDTH-1:1]};
        idx_d  = (idx_q == '0) ? last_c : idx_q - IDX_W'(1);
        wrap_d = (idx_q == '0);
      end
    end
  end

  // State registers with synchronous reset to the mode's reset pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= (mode == MODE_JOHNSON) ? JOHN_RST : RING_RST;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      mode_q <= mode;
    end else begin
      q_q    <= q_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

`ifdef SHIFT_COUNTER_GEN_SELFCORRECT_EN
  // Correction pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign q    = q_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Directed self-checking bench for shift_counter_gen (WIDTH=4 and WIDTH=5).
module tb_shift_counter_gen;

  logic       clk;
  logic       reset, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] idx;
  logic       wrap, err;

  logic       b_reset, b_en, b_mode, b_dir, b_load;
  logic [4:0] b_load_val;
  logic [4:0] b_q;
  logic [3:0] b_idx;
  logic       b_wrap, b_err;

  int checks = 0;
  int errors = 0;

  shift_counter_gen #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .idx(idx), .wrap(wrap), .err(err)
  );

  shift_counter_gen #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(b_reset), .en(b_en), .mode(b_mode), .dir(b_dir), .load(b_load),
    .load_val(b_load_val), .q(b_q), .idx(b_idx), .wrap(b_wrap), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic [2:0] ei, input logic ew);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".idx"}, 32'(idx), 32'(ei));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".err"}, 32'(err), 32'(1'b0));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0;
    b_reset = 1'b1; b_en = 1'b0; b_mode = 1'b1; b_dir = 1'b0; b_load = 1'b0; b_load_val = 5'h0;
    tick();

    // 1: reset state, ring left x4
    chk4("rst", 4'b1000, 3'd0, 1'b0);
    reset = 1'b0; en = 1'b1;
    tick(); chk4("r1", 4'b0001, 3'd1, 1'b0);
    tick(); chk4("r2", 4'b0010, 3'd2, 1'b0);
    tick(); chk4("r3", 4'b0100, 3'd3, 1'b0);
    tick(); chk4("r4", 4'b1000, 3'd0, 1'b1);
    tick(); chk4("r5", 4'b0001, 3'd1, 1'b0);

    // 2: mode change to Johnson while running, then 8 steps
    mode = 1'b1;
    tick(); chk4("mc", 4'b0000, 3'd0, 1'b0);
    tick(); chk4("j1", 4'b0001, 3'd1, 1'b0);
    tick(); chk4("j2", 4'b0011, 3'd2, 1'b0);
    tick(); chk4("j3", 4'b0111, 3'd3, 1'b0);
    tick(); chk4("j4", 4'b1111, 3'd4, 1'b0);
    tick(); chk4("j5", 4'b1110, 3'd5, 1'b0);
    tick(); chk4("j6", 4'b1100, 3'd6, 1'b0);
    tick(); chk4("j7", 4'b1000, 3'd7, 1'b0);
    tick(); chk4("j8", 4'b0000, 3'd0, 1'b1);

    // 3: ring, reset, then right steps
    mode = 1'b0; reset = 1'b1;
    tick(); chk4("rst3", 4'b1000, 3'd0, 1'b0);
    reset = 1'b0; dir = 1'b1;
    tick(); chk4("rr1", 4'b0100, 3'd3, 1'b1);
    tick(); chk4("rr2", 4'b0010, 3'd2, 1'b0);
    tick(); chk4("rr3", 4'b0001, 3'd1, 1'b0);
    tick(); chk4("rr4", 4'b1000, 3'd0, 1'b0);

    // 4: load an illegal ring pattern
    dir = 1'b0; load = 1'b1; load_val = 4'b0110;
    tick(); chk4("ld", 4'b0110, 3'd0, 1'b0);
    load = 1'b0;
    tick();
`ifdef SHIFT_COUNTER_GEN_SELFCORRECT_EN
    chk("cor.q", 32'(q), 32'(4'b1000));
    chk("cor.idx", 32'(idx), 32'(3'd0));
    chk("cor.wrap", 32'(wrap), 32'(1'b0));
    chk("cor.err", 32'(err), 32'(1'b1));
    tick(); chk4("cor2", 4'b0001, 3'd1, 1'b0);
`else
    chk4("nocor", 4'b1100, 3'd1, 1'b0);
`endif

    // 5: hold with en=0, then reset wins over load
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b1;
    tick(); tick(); chk4("h0", 4'b0010, 3'd2, 1'b0);
    en = 1'b0;
    tick(); chk4("h1", 4'b0010, 3'd2, 1'b0);
    tick(); chk4("h2", 4'b0010, 3'd2, 1'b0);
    tick(); chk4("h3", 4'b0010, 3'd2, 1'b0);
    reset = 1'b1; load = 1'b1; load_val = 4'b0101;
    tick(); chk4("rstld", 4'b1000, 3'd0, 1'b0);

    // load with a mode change: value kept, new mode adopted without reinit
    reset = 1'b0; load_val = 4'b0011; mode = 1'b1;
    tick(); chk4("ldm", 4'b0011, 3'd0, 1'b0);
    load = 1'b0; en = 1'b1;
    tick(); chk4("ldm1", 4'b0111, 3'd1, 1'b0);
    en = 1'b0;

    // 6: WIDTH=5 Johnson
    b_reset = 1'b0; b_en = 1'b1;
    chk("w5.rst.q", 32'(b_q), 32'(5'b00000));
    chk("w5.rst.idx", 32'(b_idx), 32'(4'd0));
    for (int i = 0; i < 9; i++) tick();
    chk("w5.s9.q", 32'(b_q), 32'(5'b10000));
    chk("w5.s9.idx", 32'(b_idx), 32'(4'd9));
    chk("w5.s9.wrap", 32'(b_wrap), 32'(1'b0));
    tick();
    chk("w5.s10.q", 32'(b_q), 32'(5'b00000));
    chk("w5.s10.idx", 32'(b_idx), 32'(4'd0));
    chk("w5.s10.wrap", 32'(b_wrap), 32'(1'b1));
    tick();
    chk("w5.l.q", 32'(b_q), 32'(5'b00001));
    chk("w5.l.idx", 32'(b_idx), 32'(4'd1));
    b_dir = 1'b1;
    tick();
    chk("w5.r.q", 32'(b_q), 32'(5'b00000));
    chk("w5.r.idx", 32'(b_idx), 32'(4'd0));
    chk("w5.r.wrap", 32'(b_wrap), 32'(1'b0));
    tick();
    chk("w5.r2.q", 32'(b_q), 32'(5'b10000));
    chk("w5.r2.idx", 32'(b_idx), 32'(4'd9));
    chk("w5.r2.wrap", 32'(b_wrap), 32'(1'b1));
    chk("w5.err", 32'(b_err), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
